// File: rtl/gbr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gbr_pkg
// Description : Shared sizing constants, FSM state encoding and the stop
//               coordinate table for the route-fitness pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package gbr_pkg;

    localparam int POP_SIZE  = 50;
    localparam int NUM_STOPS = 8;
    localparam int STOP_W    = 3;
    localparam int COORD_W   = 8;
    localparam int DIST_W    = 12;
    localparam int IDX_W     = 6;
    localparam int LEG_W     = $clog2(NUM_STOPS);
    localparam int STATE_W   = 3;

    // Evaluator states
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_ACCUM = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Stop k sits at x = 32k
    function automatic logic [COORD_W-1:0] stop_x(input logic [STOP_W-1:0] k);
        return COORD_W'({k, 5'b00000});
    endfunction

    // Even stops sit on y = 0, odd stops on y = 64
    function automatic logic [COORD_W-1:0] stop_y(input logic [STOP_W-1:0] k);
        return k[0] ? COORD_W'(64) : '0;
    endfunction

endpackage : gbr_pkg
`default_nettype wire

// File: rtl/stop_coord_rom.sv
`default_nettype none
// ============================================================================
// Module      : stop_coord_rom
// Description : Combinational two-port lookup from stop index to (x, y).
//               Port A and port B serve the two endpoints of one tour leg.
// Revision    : 1.0 - initial release
// ============================================================================
module stop_coord_rom
    import gbr_pkg::*;
(
    input  logic [STOP_W-1:0]  stop_a_i,
    input  logic [STOP_W-1:0]  stop_b_i,
    output logic [COORD_W-1:0] xa_o,
    output logic [COORD_W-1:0] ya_o,
    output logic [COORD_W-1:0] xb_o,
    output logic [COORD_W-1:0] yb_o
);

    assign xa_o = stop_x(stop_a_i);
    assign ya_o = stop_y(stop_a_i);
    assign xb_o = stop_x(stop_b_i);
    assign yb_o = stop_y(stop_b_i);

endmodule : stop_coord_rom
`default_nettype wire

// File: rtl/pop_fitness_eval.sv
`default_nettype none
// ============================================================================
// Module      : pop_fitness_eval
// Description : Walks the population, fetches each genome from a synchronous
//               memory and accumulates the closed-tour Manhattan distance one
//               leg per cycle. Raises done when all distances are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_fitness_eval
    import gbr_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [IDX_W-1:0]              genome_addr,
    input  logic [NUM_STOPS*STOP_W-1:0]   genome_data,
    output logic [DIST_W-1:0]             distances [POP_SIZE-1:0],
    output logic                          done
);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [DIST_W-1:0]             acc_q, acc_d;
    logic [LEG_W-1:0]              leg_q, leg_d;
    logic [NUM_STOPS*STOP_W-1:0]   genome_q, genome_d;
    logic [DIST_W-1:0]             dist_q [POP_SIZE-1:0];

    logic [LEG_W-1:0]              leg_nxt;
    logic [STOP_W-1:0]             stop_a, stop_b;
    logic [COORD_W-1:0]            xa, ya, xb, yb;
    logic signed [COORD_W:0]       dx, dy;
    logic [COORD_W-1:0]            adx, ady;
    logic [COORD_W:0]              leg_len;
    logic [DIST_W-1:0]             acc_sum;
    logic                          last_leg;

    // Leg endpoints: stop[k] and stop[k+1], wrapping to stop[0] to close the tour
    always_comb begin
        leg_nxt = (leg_q == LEG_W'(NUM_STOPS - 1)) ? '0 : leg_q + 1'b1;
        stop_a  = genome_q[leg_q * STOP_W +: STOP_W];
        stop_b  = genome_q[leg_nxt * STOP_W +: STOP_W];
    end

    stop_coord_rom u_rom (
        .stop_a_i (stop_a),
        .stop_b_i (stop_b),
        .xa_o     (xa),
        .ya_o     (ya),
        .xb_o     (xb),
        .yb_o     (yb)
    );

    // Manhattan leg length; worst case 255 + 255 fits the tour width without overflow
    always_comb begin
        dx       = $signed({1'b0, xa}) - $signed({1'b0, xb});
        dy       = $signed({1'b0, ya}) - $signed({1'b0, yb});
        adx      = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
        ady      = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
        leg_len  = {1'b0, adx} + {1'b0, ady};
        acc_sum  = acc_q + DIST_W'(leg_len);
        last_leg = (state_q == ST_ACCUM) && (leg_q == LEG_W'(NUM_STOPS - 1));
    end

    // Sequencer: one FETCH, one WAIT for the synchronous memory, NUM_STOPS ACCUM
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        leg_d    = leg_q;
        genome_d = genome_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                genome_d = genome_data;
                acc_d    = '0;
                leg_d    = '0;
                state_d  = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_d = acc_sum;
                leg_d = leg_nxt;
                if (last_leg) begin
                    if (idx_q < IDX_W'(POP_SIZE - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            leg_q    <= '0;
            genome_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            leg_q    <= leg_d;
            genome_q <= genome_d;
        end
    end

    // Result array: only the current individual's entry is written, on its last leg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < POP_SIZE; i++) begin
                dist_q[i] <= '0;
            end
        end else if (last_leg) begin
            dist_q[idx_q] <= acc_sum;
        end
    end

    // idx only changes on entry to FETCH, so it doubles as the held memory address
    assign genome_addr = idx_q;
    assign distances   = dist_q;
    assign done        = (state_q == ST_DONE);

endmodule : pop_fitness_eval
`default_nettype wire

// File: doc/pop_fitness_eval.md
# pop_fitness_eval

Computes the route distance (fitness) of every individual in the population and presents the 50×12-bit distance array that the population sorter consumes. Each genome is an ordered tour of NUM_STOPS stops. The block fetches one genome per individual from the population memory and accumulates the Manhattan length of the closed tour, one leg per cycle. It raises `done` once all POP_SIZE distances are valid; `done` drives the sorter's `start`.

## Interface
- POP_SIZE, 50, individuals per generation
- NUM_STOPS, 8, stops per tour
- STOP_W, 3, bits per stop index
- COORD_W, 8, bits per x/y coordinate
- DIST_W, 12, distance width
- IDX_W, 6, individual index width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level; sampled in IDLE or DONE to begin a run
- genome_addr  output  IDX_W  individual index for population memory read
- genome_data  input  NUM_STOPS*STOP_W  genome at `genome_addr`; valid exactly one cycle after the address is driven (synchronous read); stop k in bits [k*STOP_W +: STOP_W]
- distances  output  DIST_W × POP_SIZE (unpacked array [POP_SIZE-1:0])  tour length per individual
- done  output  1  high while in DONE; distances all valid

## Operation
- States:
  - IDLE → FETCH on start.
  - FETCH → WAIT.
  - WAIT → ACCUM; captures genome_data into a genome register; acc=0, leg=0.
  - ACCUM runs NUM_STOPS cycles.
  - After the last leg: if idx<POP_SIZE-1, idx+1 and → FETCH; else → DONE.
  - DONE holds until start is high again, then → FETCH with idx=0 (re-run).
- FETCH drives genome_addr=idx; genome_addr holds its value in WAIT and ACCUM.
- ACCUM, leg k: a=stop[k], b=stop[(k+1) mod NUM_STOPS]; acc += |xa−xb| + |ya−yb|.
- The leg from stop[NUM_STOPS-1] back to stop[0] closes the tour.
- On the last leg, distances[idx] ← acc + final leg; only this entry is written.
- Arithmetic:
  - Differences are computed at COORD_W+1 bits signed; the absolute value is taken to COORD_W bits.
  - Leg ≤ 510; tour ≤ 8×510 = 4080 < 2^12, so no saturation or overflow logic is needed.
- Duplicate stops in a genome are not checked or penalized; the distance is computed as given.
- start while in FETCH/WAIT/ACCUM is ignored.
- During a run, entries not yet rewritten keep the previous run's values; consumers must qualify them with done.
- Reset (any time, including mid-run): state=IDLE, idx=0, acc=0, leg=0, genome register=0, genome_addr=0, all distances=0, done=0.

## Timing
- Start sampled at edge E0 in IDLE: FETCH occupies cycle 1.
- Individual i occupies cycles 1+(NUM_STOPS+2)i … (NUM_STOPS+2)(i+1).
- distances[i] is updated at the end of its last ACCUM cycle.
- done rises (NUM_STOPS+2)·POP_SIZE+1 cycles after E0: 501 at defaults.
- done is level and stays high until the edge after start is sampled in DONE; it goes low in the following FETCH cycle.
- Throughput: NUM_STOPS+2 cycles per individual, with no stalls.

## Structure
- Shared package gbr_pkg holds:
  - POP_SIZE, NUM_STOPS, STOP_W, COORD_W, DIST_W, IDX_W
  - the state enum (IDLE, FETCH, WAIT, ACCUM, DONE)
  - the stop coordinate table: stop k at x=32k, y=0 (k even) or 64 (k odd)
- Sub-module stop_coord_rom: combinational, two read ports (stop index → x,y), contents from gbr_pkg.
- Leg adder and FSM live in pop_fitness_eval.

## Test plan
- All 50 genomes = 0x000000 (every stop 0); start for one cycle → every distances[i]=0; done rises exactly 501 cycles after the start edge.
- All genomes = 0xFAC688 (tour 0,1,…,7): 7 legs × 96 + closing 288 → all distances[i]=960.
- Genome i=0 set to alternating 0,1,0,1,… (0x208208), genome i=49 set to 0xFAC688, rest zero → distances[0]=768, distances[49]=960, others 0.
  - Also check genome_addr steps 0…49, each index held for 10 cycles.
- Pulse start again at cycle 200 of a run → ignored; done timing unchanged.
  - Then hold start high in DONE → rerun; done low for 500 cycles, then high with identical results.
- Assert rst at cycle 250 of a run → outputs zero asynchronously; distances all 0, done=0, state IDLE.
  - A new start then completes normally with correct values.
- Memory model returns data only one cycle after address → confirm correct sampling.
  - With data deliberately changed in the ACCUM cycles, the results are unaffected.
